ysyx_22041752_axi_sram_slave: RTL and testbench
===============================================

// Module: ysyx_22041752_axi_sram_slave
// PURPOSE
//  AXI4 slave memory model sitting directly downstream of the core top's io_master port.
//  Terminates all five AXI channels into a behavioural 64-bit-wide SRAM array.
//  Gives the core bench a cycle-accurate target for IFU/EXU traffic, with backpressure and bursts.
//  Services one transaction at a time; read/write contention is round-robin arbitrated.
// PARAMETERS
//  BASE    32'h8000_0000  byte address of word 0
//  DEPTH   65536          number of 64-bit words; word index = (addr-BASE)>>3
//  IDX_W   16             log2(DEPTH)
// PORTS
//  clock     in   1   system clock, all logic posedge
//  reset     in   1   synchronous, active-high
//  awready   out  1   AW accepted (IDLE only)
//  awvalid   in   1   AW valid
//  awid      in   4   write id
//  awaddr    in   32  write start byte address
//  awlen     in   8   beats-1
//  awsize    in   3   log2 bytes per beat
//  awburst   in   2   00 FIXED, 01 INCR, 10 WRAP
//  wready    out  1   W accepted (WR_DATA only)
//  wvalid    in   1   W valid
//  wdata     in   64  write data
//  wstrb     in   8   byte enables for wdata
//  wlast     in   1   master's last-beat flag
//  bready    in   1   master accepts B
//  bvalid    out  1   B valid
//  bid       out  4   equals latched awid
//  bresp     out  2   00 OKAY, 10 SLVERR, 11 DECERR
//  arready   out  1   AR accepted (IDLE only)
//  arvalid   in   1   AR valid
//  arid      in   4   read id
//  araddr    in   32  read start byte address
//  arlen     in   8   beats-1
//  arsize    in   3   log2 bytes per beat
//  arburst   in   2   as awburst
//  rready    in   1   master accepts R
//  rvalid    out  1   R valid
//  rid       out  4   equals latched arid
//  rdata     out  64  full aligned 64-bit word; master selects byte lanes
//  rresp     out  2   as bresp
//  rlast     out  1   high on beat index == arlen
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high.
//  - Reset state:
//      - state=IDLE, last_grant=0 (write).
//      - All ready/valid outputs 0; rdata, rid, bid, rresp, bresp and rlast 0.
//      - The SRAM array is not reset.
//  - FSM states: IDLE, RD, WR_DATA, WR_RESP.
//  - IDLE:
//      - arready and awready are combinational from state and the arbiter grant.
//      - Only one of arready/awready is ever high.
//      - If only one of arvalid/awvalid is high, that channel is granted.
//      - If both are high, grant the channel opposite last_grant, then update last_grant.
//  - Read path:
//      - AR handshake at cycle T latches id, addr, len, size and burst; beat=0; go to RD.
//      - rvalid is high from T+1 and carries registered mem[idx].
//      - Each R handshake advances addr and beat, and the next beat's data is valid the
//        following cycle (back-to-back, no bubble).
//      - On a handshake with rlast=1, return to IDLE.
//      - R outputs hold stable while rvalid && !rready.
//  - Write path:
//      - AW handshake at cycle T latches id, addr, len, size and burst; wready is high from T+1.
//      - Each W handshake writes only the strobed bytes of mem[idx]; the written data is
//        visible to a read starting the next cycle.
//      - On the handshake where beat==awlen, go to WR_RESP with bvalid=1.
//      - In WR_RESP, hold bvalid/bid/bresp until bready, then go to IDLE.
//  - Address step:
//      - INCR: addr += (1<<size), 32-bit wrap-around ignored.
//      - FIXED: addr unchanged.
//  - Error responses (per beat):
//      - idx >= DEPTH or addr < BASE: DECERR.
//      - WRAP burst or size > 3: SLVERR on all beats.
//      - Any errored beat returns rdata=0 or performs no write.
//      - The full burst length is still honoured.
//      - bresp reports the worst error seen over all beats.
//      - wlast != (beat==awlen) on any beat forces bresp=SLVERR; the FSM still exits on
//        beat==awlen.
//  - Reset mid-burst: abort immediately to IDLE with outputs cleared; partial writes remain.
// TESTING
//  - Single read:
//      - Stimulus: preload mem[0]=64'h1122334455667788; AR addr=0x8000_0000 len=0 size=3
//        INCR at T; rready=1.
//      - Required: rvalid@T+1, rdata=1122334455667788, rlast=1, rresp=00.
//  - INCR burst with backpressure:
//      - Stimulus: AR len=3 at 0x8000_0010; rready toggles 1/0.
//      - Required: 4 beats of mem[2..5] in order, data held while stalled, rlast on beat 3.
//  - Strobed write then read:
//      - Stimulus: AW 0x8000_0008 len=0; W data=FFFF_FFFF_FFFF_FFFF wstrb=8'h0F, old word 0.
//      - Required: bresp=00 and bid=awid; subsequent read = 0000_0000_FFFF_FFFF.
//  - Simultaneous AR and AW in IDLE after reset (last_grant=0):
//      - Required: read granted first, write granted next.
//  - Error responses:
//      - AR addr=0x0000_0000: rresp=11 and rdata=0.
//      - AW WRAP len=1: two wready beats, bresp=10, memory unchanged.
//  - Reset mid-burst:
//      - Stimulus: reset asserted during beat 2 of a len=7 read.
//      - Required: next cycle rvalid=0, arready is reasserted, and a new read completes correctly.

Source files
------------

// File: rtl/ysyx_22041752_axi_sram_slave.sv
// AXI4 slave memory model: terminates AW/W/B/AR/R into a 64-bit-wide SRAM array.
// One transaction is in flight at a time; AR/AW contention is round-robin arbitrated.
module ysyx_22041752_axi_sram_slave #(
   parameter logic [31:0] BASE  = 32'h8000_0000,
   parameter int          DEPTH = 65536,
   parameter int          IDX_W = 16
) (
   input  logic        clock,
   input  logic        reset,
   output logic        awready,
   input  logic        awvalid,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   output logic        wready,
   input  logic        wvalid,
   input  logic [63:0] wdata,
   input  logic [7:0]  wstrb,
   input  logic        wlast,
   input  logic        bready,
   output logic        bvalid,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        arready,
   input  logic        arvalid,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic        rready,
   output logic        rvalid,
   output logic [3:0]  rid,
   output logic [63:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic [1:0]  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // Our valids never wait on ready; IDLE readies are derived from the pending valids.

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD      = 2'd1,
      WR_DATA = 2'd2,
      WR_RESP = 2'd3
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   state_t      state;
   logic        last_grant;   // 1: read was granted last, 0: write
   logic [31:0] xfer_addr;
   logic [7:0]  xfer_len;
   logic [2:0]  xfer_size;
   logic [1:0]  xfer_burst;
   logic [7:0]  beat;
   logic [1:0]  wr_acc;

   logic [63:0] mem [DEPTH];

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE;
      return IDX_W'(off >> 3);
   endfunction

   function automatic logic [1:0] beat_resp(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
      logic [31:0] off;
      logic [1:0]  resp;
      off  = addr - BASE;
      resp = RESP_OKAY;
      if (burst == BURST_WRAP || size > 3'd3)
         resp = RESP_SLVERR;
      if (addr < BASE || (off >> 3) >= 32'(DEPTH))
         resp = RESP_DECERR;
      return resp;
   endfunction

   // Response codes are ordered so that the numerically larger one is the worse one.
   function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [31:0] step_addr(input logic [31:0] addr,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst);
      return (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);
   endfunction

   logic             grant_rd;
   logic             grant_wr;
   logic             r_fire;
   logic             w_fire;
   logic             mem_we;
   logic [31:0]      nxt_addr;
   logic [1:0]       nxt_resp;
   logic [IDX_W-1:0] nxt_idx;
   logic [1:0]       ar_resp;
   logic [IDX_W-1:0] ar_idx;
   logic [1:0]       cur_resp;
   logic [IDX_W-1:0] cur_idx;
   logic [1:0]       last_err;

   always_comb begin
      grant_rd = arvalid && (!awvalid || !last_grant);
      grant_wr = awvalid && !grant_rd;
      arready  = !reset && (state == IDLE) && grant_rd;
      awready  = !reset && (state == IDLE) && grant_wr;
      wready   = !reset && (state == WR_DATA);
      r_fire   = rvalid && rready;
      w_fire   = wvalid && wready;
      nxt_addr = step_addr(xfer_addr, xfer_size, xfer_burst);
      nxt_resp = beat_resp(nxt_addr, xfer_size, xfer_burst);
      nxt_idx  = word_idx(nxt_addr);
      ar_resp  = beat_resp(araddr, arsize, arburst);
      ar_idx   = word_idx(araddr);
      cur_resp = beat_resp(xfer_addr, xfer_size, xfer_burst);
      cur_idx  = word_idx(xfer_addr);
      last_err = (wlast != (beat == xfer_len)) ? RESP_SLVERR : RESP_OKAY;
      mem_we   = w_fire && (cur_resp == RESP_OKAY);
   end

   assign dbg_state = state;

   // The array holds no reset; errored beats never reach it.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int b = 0; b < 8; b++) begin
            if (wstrb[b])
               mem[cur_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b0;
         xfer_addr  <= '0;
         xfer_len   <= '0;
         xfer_size  <= '0;
         xfer_burst <= '0;
         beat       <= '0;
         wr_acc     <= RESP_OKAY;
         rvalid     <= 1'b0;
         rid        <= '0;
         rdata      <= '0;
         rresp      <= RESP_OKAY;
         rlast      <= 1'b0;
         bvalid     <= 1'b0;
         bid        <= '0;
         bresp      <= RESP_OKAY;
      end else begin
         case (state)
            IDLE: begin
               if (arvalid && arready) begin
                  state      <= RD;
                  last_grant <= 1'b1;
                  xfer_addr  <= araddr;
                  xfer_len   <= arlen;
                  xfer_size  <= arsize;
                  xfer_burst <= arburst;
                  beat       <= '0;
                  rvalid     <= 1'b1;
                  rid        <= arid;
                  rdata      <= (ar_resp == RESP_OKAY) ? mem[ar_idx] : '0;
                  rresp      <= ar_resp;
                  rlast      <= (arlen == 8'd0);
               end else if (awvalid && awready) begin
                  state      <= WR_DATA;
                  last_grant <= 1'b0;
                  xfer_addr  <= awaddr;
                  xfer_len   <= awlen;
                  xfer_size  <= awsize;
                  xfer_burst <= awburst;
                  beat       <= '0;
                  wr_acc     <= RESP_OKAY;
                  bid        <= awid;
               end
            end
            RD: begin
               if (r_fire) begin
                  if (rlast) begin
                     state  <= IDLE;
                     rvalid <= 1'b0;
                     rlast  <= 1'b0;
                  end else begin
                     // Fetch the next beat now so it is presented without a bubble.
                     xfer_addr <= nxt_addr;
                     beat      <= beat + 8'd1;
                     rdata     <= (nxt_resp == RESP_OKAY) ? mem[nxt_idx] : '0;
                     rresp     <= nxt_resp;
                     rlast     <= ((beat + 8'd1) == xfer_len);
                  end
               end
            end
            WR_DATA: begin
               if (w_fire) begin
                  if (beat == xfer_len) begin
                     state  <= WR_RESP;
                     bvalid <= 1'b1;
                     bresp  <= worst(wr_acc, worst(cur_resp, last_err));
                  end else begin
                     xfer_addr <= nxt_addr;
                     beat      <= beat + 8'd1;
                     wr_acc    <= worst(wr_acc, worst(cur_resp, last_err));
                  end
               end
            end
            WR_RESP: begin
               if (bready) begin
                  state  <= IDLE;
                  bvalid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_one_ready: assert property (@(posedge clock) !(arready && awready));

   a_r_stable: assert property (@(posedge clock) disable iff (reset)
      (rvalid && !rready) |=> (rvalid && $stable({rid, rresp, rlast, rdata})));

   a_b_stable: assert property (@(posedge clock) disable iff (reset)
      (bvalid && !bready) |=> (bvalid && $stable({bid, bresp})));

endmodule

// File: tb/tb_ysyx_22041752_axi_sram_slave.sv
// Directed bench for ysyx_22041752_axi_sram_slave: drivers push expected R/B responses
// into queues, a negedge monitor pops and compares whenever a handshake is presented.
`timescale 1ns/1ps
module tb_ysyx_22041752_axi_sram_slave;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam logic [63:0] M0   = 64'h1122_3344_5566_7788;
   localparam logic [63:0] D2   = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] D3   = 64'hFEDC_BA98_7654_3210;
   localparam logic [63:0] D4   = 64'hA5A5_5A5A_0F0F_F0F0;
   localparam logic [63:0] D5   = 64'hCAFE_F00D_DEAD_BEEF;
   localparam logic [63:0] D6   = 64'h6666_0000_6666_0000;
   localparam logic [63:0] D7   = 64'h7777_1111_7777_1111;

   logic        clock = 1'b0;
   logic        reset;
   logic        awready, awvalid, wready, wvalid, wlast, bready, bvalid;
   logic [3:0]  awid, bid, arid, rid;
   logic [31:0] awaddr, araddr;
   logic [7:0]  awlen, arlen, wstrb;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp, dbg_state;
   logic [63:0] wdata, rdata;
   logic        arready, arvalid, rready, rvalid, rlast;

   int n_cmp = 0;
   int n_err = 0;
   logic [70:0] exp_r_q[$];
   logic [5:0]  exp_b_q[$];
   logic [63:0] wbuf [8];
   logic        rr_toggle = 1'b0;
   logic        rr_level  = 1'b1;

   ysyx_22041752_axi_sram_slave dut (
      .clock(clock), .reset(reset),
      .awready(awready), .awvalid(awvalid), .awid(awid), .awaddr(awaddr), .awlen(awlen),
      .awsize(awsize), .awburst(awburst),
      .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bready(bready), .bvalid(bvalid), .bid(bid), .bresp(bresp),
      .arready(arready), .arvalid(arvalid), .arid(arid), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arburst(arburst),
      .rready(rready), .rvalid(rvalid), .rid(rid), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .dbg_state(dbg_state)
   );

   // Clock/reset
   always #5 clock = ~clock;

   function automatic void chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: event did not occur as required", name);
   endfunction

   // rready driver: steady level or toggling every cycle
   initial begin
      rready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         rready = rr_toggle ? !rready : rr_level;
      end
   end

   // Monitor / scoreboard
   initial begin
      logic        stall_q;
      logic [70:0] stall_v;
      logic [70:0] er;
      logic [5:0]  eb;
      stall_q = 1'b0;
      stall_v = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            stall_q = 1'b0;
         end else begin
            if (stall_q)
               chk("r_hold", {rvalid, rid, rresp, rlast, rdata}, {1'b1, stall_v});
            if (rvalid && rready) begin
               if (exp_r_q.size() == 0) fail("r_unexpected");
               else begin
                  er = exp_r_q.pop_front();
                  chk("r_beat", 72'({rid, rresp, rlast, rdata}), 72'(er));
               end
            end
            stall_q = rvalid && !rready;
            stall_v = {rid, rresp, rlast, rdata};
            if (bvalid && bready) begin
               if (exp_b_q.size() == 0) fail("b_unexpected");
               else begin
                  eb = exp_b_q.pop_front();
                  chk("b_resp", 72'({bid, bresp}), 72'(eb));
               end
            end
         end
      end
   end

   // Driver tasks: entered and left 1ns after a rising edge
   task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output int waited);
      waited  = 0;
      arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
      @(negedge clock);
      while (!arready && waited < 50) begin
         waited++;
         @(negedge clock);
      end
      if (!arready) fail("ar_timeout");
      @(posedge clock);
      #1;
      arvalid = 1'b0;
   endtask

   task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
      int n = 0;
      awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst;
      @(negedge clock);
      while (!awready && n < 50) begin
         n++;
         @(negedge clock);
      end
      if (!awready) fail("aw_timeout");
      @(posedge clock);
      #1;
      awvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
      int n = 0;
      wvalid = 1'b1; wdata = data; wstrb = strb; wlast = last;
      @(negedge clock);
      while (!wready && n < 50) begin
         n++;
         @(negedge clock);
      end
      if (!wready) fail("w_timeout");
      @(posedge clock);
      #1;
      wvalid = 1'b0;
   endtask

   task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [7:0] strb, input logic [1:0] resp);
      exp_b_q.push_back({id, resp});
      aw_send(id, addr, len, burst);
      for (int i = 0; i <= int'(len); i++)
         w_beat(wbuf[i], strb, i == int'(len));
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((exp_r_q.size() != 0 || exp_b_q.size() != 0 || dbg_state != 2'd0) && n < 300) begin
         @(posedge clock);
         #1;
         n++;
      end
      if (n >= 300) fail(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int n;
      reset   = 1'b1;
      arvalid = 1'b1; arid = 4'd1; araddr = BASE; arlen = '0; arsize = 3'd3; arburst = 2'b01;
      awvalid = 1'b1; awid = 4'd1; awaddr = BASE; awlen = '0; awsize = 3'd3; awburst = 2'b01;
      wvalid  = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
      bready  = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_readies", 72'({arready, awready, wready}), 72'(0));
      chk("rst_valids", 72'({rvalid, bvalid, rlast}), 72'(0));
      chk("rst_rdata", 72'(rdata), 72'(0));
      chk("rst_ids_resps", 72'({rid, bid, rresp, bresp}), 72'(0));
      chk("rst_state", 72'(dbg_state), 72'(0));
      @(posedge clock);
      #1;
      arvalid = 1'b0; awvalid = 1'b0; reset = 1'b0;

      // Preload mem[0..5]
      wbuf[0] = M0; wbuf[1] = '0; wbuf[2] = D2; wbuf[3] = D3; wbuf[4] = D4; wbuf[5] = D5;
      write_burst(4'd1, BASE, 8'd5, 2'b01, 8'hFF, 2'b00);
      wait_done("preload_done");

      // Single read, first-beat latency
      exp_r_q.push_back({4'd2, 2'b00, 1'b1, M0});
      ar_send(4'd2, BASE, 8'd0, 3'd3, 2'b01, w);
      chk("rd_latency", 72'(rvalid), 72'(1));
      wait_done("single_rd_done");

      // INCR burst with rready toggling
      exp_r_q.push_back({4'd3, 2'b00, 1'b0, D2});
      exp_r_q.push_back({4'd3, 2'b00, 1'b0, D3});
      exp_r_q.push_back({4'd3, 2'b00, 1'b0, D4});
      exp_r_q.push_back({4'd3, 2'b00, 1'b1, D5});
      rr_toggle = 1'b1;
      ar_send(4'd3, BASE + 32'h10, 8'd3, 3'd3, 2'b01, w);
      wait_done("incr_rd_done");
      rr_toggle = 1'b0;
      rr_level  = 1'b1;
      @(posedge clock);
      #1;

      // FIXED burst repeats the same word
      exp_r_q.push_back({4'd4, 2'b00, 1'b0, D3});
      exp_r_q.push_back({4'd4, 2'b00, 1'b0, D3});
      exp_r_q.push_back({4'd4, 2'b00, 1'b1, D3});
      ar_send(4'd4, BASE + 32'h18, 8'd2, 3'd3, 2'b00, w);
      wait_done("fixed_rd_done");

      // Strobed write with B backpressure, then read back
      bready = 1'b0;
      exp_b_q.push_back({4'd5, 2'b00});
      aw_send(4'd5, BASE + 32'h8, 8'd0, 2'b01);
      w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1);
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("b_held", 72'({bvalid, bid, bresp}), 72'({1'b1, 4'd5, 2'b00}));
      @(posedge clock);
      #1;
      bready = 1'b1;
      wait_done("strb_wr_done");
      exp_r_q.push_back({4'd6, 2'b00, 1'b1, 64'h0000_0000_FFFF_FFFF});
      ar_send(4'd6, BASE + 32'h8, 8'd0, 3'd3, 2'b01, w);
      wait_done("strb_rd_done");

      // Reset last_grant, then AR and AW together: read wins, write follows
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      exp_r_q.push_back({4'd3, 2'b00, 1'b1, M0});
      exp_b_q.push_back({4'd4, 2'b00});
      arvalid = 1'b1; arid = 4'd3; araddr = BASE; arlen = '0; arsize = 3'd3; arburst = 2'b01;
      awvalid = 1'b1; awid = 4'd4; awaddr = BASE + 32'h30; awlen = '0; awsize = 3'd3; awburst = 2'b01;
      @(negedge clock);
      chk("arb_rd_first", 72'({arready, awready}), 72'(2'b10));
      @(posedge clock);
      #1;
      arvalid = 1'b0;
      n = 0;
      @(negedge clock);
      while (!awready && n < 50) begin
         n++;
         @(negedge clock);
      end
      if (!awready) fail("arb_wr_next");
      chk("arb_order", 72'(exp_r_q.size()), 72'(0));
      @(posedge clock);
      #1;
      awvalid = 1'b0;
      w_beat(D6, 8'hFF, 1'b1);
      wait_done("arb1_done");

      // After a read grant, simultaneous requests go to the write
      exp_r_q.push_back({4'd8, 2'b00, 1'b1, D6});
      ar_send(4'd8, BASE + 32'h30, 8'd0, 3'd3, 2'b01, w);
      wait_done("rd6_done");
      exp_r_q.push_back({4'd9, 2'b00, 1'b1, D7});
      exp_b_q.push_back({4'd10, 2'b00});
      arvalid = 1'b1; arid = 4'd9; araddr = BASE + 32'h38; arlen = '0; arsize = 3'd3; arburst = 2'b01;
      awvalid = 1'b1; awid = 4'd10; awaddr = BASE + 32'h38; awlen = '0; awsize = 3'd3; awburst = 2'b01;
      @(negedge clock);
      chk("arb_wr_first", 72'({arready, awready}), 72'(2'b01));
      @(posedge clock);
      #1;
      awvalid = 1'b0;
      w_beat(D7, 8'hFF, 1'b1);
      ar_send(4'd9, BASE + 32'h38, 8'd0, 3'd3, 2'b01, w);
      wait_done("arb2_done");

      // Error responses
      exp_r_q.push_back({4'd9, 2'b11, 1'b1, 64'h0});
      ar_send(4'd9, 32'h0000_0000, 8'd0, 3'd3, 2'b01, w);
      exp_r_q.push_back({4'd10, 2'b11, 1'b1, 64'h0});
      ar_send(4'd10, 32'h8008_0000, 8'd0, 3'd3, 2'b01, w);
      exp_r_q.push_back({4'd11, 2'b10, 1'b1, 64'h0});
      ar_send(4'd11, BASE, 8'd0, 3'd4, 2'b01, w);
      wait_done("err_rd_done");
      wbuf[0] = 64'hDEAD_DEAD_DEAD_DEAD; wbuf[1] = 64'hBEEF_BEEF_BEEF_BEEF;
      write_burst(4'd7, BASE, 8'd1, 2'b10, 8'hFF, 2'b10);
      wait_done("wrap_wr_done");
      exp_r_q.push_back({4'd12, 2'b00, 1'b1, M0});
      ar_send(4'd12, BASE, 8'd0, 3'd3, 2'b01, w);
      wait_done("wrap_chk_done");
      exp_b_q.push_back({4'd12, 2'b10});
      aw_send(4'd12, BASE + 32'h40, 8'd0, 2'b01);
      w_beat(64'h1, 8'hFF, 1'b0);
      wait_done("wlast_err_done");

      // Reset during beat 2 of a len=7 read
      exp_r_q.push_back({4'd13, 2'b00, 1'b0, M0});
      exp_r_q.push_back({4'd13, 2'b00, 1'b0, 64'h0000_0000_FFFF_FFFF});
      ar_send(4'd13, BASE, 8'd7, 3'd3, 2'b01, w);
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      chk("rst_mid_rvalid", 72'({rvalid, rlast}), 72'(0));
      chk("rst_mid_state", 72'(dbg_state), 72'(0));
      chk("rst_mid_beats", 72'(exp_r_q.size()), 72'(0));
      exp_r_q.push_back({4'd14, 2'b00, 1'b1, D2});
      ar_send(4'd14, BASE + 32'h10, 8'd0, 3'd3, 2'b01, w);
      chk("rst_mid_arready", 72'(w), 72'(0));
      wait_done("rst_mid_done");

      repeat (2) @(posedge clock);
      chk("r_queue_empty", 72'(exp_r_q.size()), 72'(0));
      chk("b_queue_empty", 72'(exp_b_q.size()), 72'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
